regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the register bank's single write port between the load unit and the
// ALU writeback path. Loads have strict priority and are always accepted. ALU
// results go through a small pending FIFO, or straight to the write port when
// the FIFO is empty and no load competes. A scoreboard reports which source
// registers still have a write in flight.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   alu_valid/alu_ready           ALU result handshake (ready depends only on count)
//   alu_addr, alu_data            ALU destination register and result
//   mem_valid, mem_addr, mem_data load result, never back-pressured
//   rf_write_enable/address/value registered write port to the register bank
//   rs1, rs2 -> rs1_busy, rs2_busy  combinational in-flight lookup
//   fifo_count                    occupied ALU FIFO entries
module regfile_write_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_W-1:0]            alu_addr,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic                         mem_valid,
    input  logic [ADDR_W-1:0]            mem_addr,
    input  logic [DATA_W-1:0]            mem_data,
    output logic                         rf_write_enable,
    output logic [ADDR_W-1:0]            rf_write_address,
    output logic [DATA_W-1:0]            rf_write_value,
    input  logic [ADDR_W-1:0]            rs1,
    input  logic [ADDR_W-1:0]            rs2,
    output logic                         rs1_busy,
    output logic                         rs2_busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  q_valid;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic mem_take;
    logic alu_live;
    logic fifo_empty;
    logic pop;
    logic bypass;
    logic push;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Handshake and arbitration decisions; zero-register traffic is filtered out.
    always_comb begin
        alu_ready  = (count < CNT_W'(DEPTH));
        fifo_empty = (count == '0);
        mem_take   = mem_valid && (mem_addr != '0);
        alu_live   = alu_valid && alu_ready && (alu_addr != '0);
        pop        = !mem_take && !fifo_empty;
        bypass     = !mem_take && fifo_empty && alu_live;
        push       = alu_live && !bypass;
    end

    assign fifo_count = count;

    // FIFO control state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_valid <= '0;
        end else begin
            // push and pop never hit the same slot: push needs room, pop needs data.
            if (push) begin
                q_valid[tail] <= 1'b1;
                tail          <= ptr_inc(tail);
            end
            if (pop) begin
                q_valid[head] <= 1'b0;
                head          <= ptr_inc(head);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO payload storage; contents are qualified by q_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= alu_addr;
            q_data[tail] <= alu_data;
        end
    end

    // Write-port output register: load, then FIFO head, then ALU bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_write_enable  <= 1'b0;
            rf_write_address <= '0;
            rf_write_value   <= '0;
        end else if (mem_take) begin
            rf_write_enable  <= 1'b1;
            rf_write_address <= mem_addr;
            rf_write_value   <= mem_data;
        end else if (pop) begin
            rf_write_enable  <= 1'b1;
            rf_write_address <= q_addr[head];
            rf_write_value   <= q_data[head];
        end else if (bypass) begin
            rf_write_enable  <= 1'b1;
            rf_write_address <= alu_addr;
            rf_write_value   <= alu_data;
        end else begin
            rf_write_enable  <= 1'b0;
        end
    end

    // Scoreboard: a register is busy while queued, in the output stage, or
    // arriving from the load unit this cycle. r0 is never busy.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && (q_addr[i] == rs1)) rs1_busy = 1'b1;
            if (q_valid[i] && (q_addr[i] == rs2)) rs2_busy = 1'b1;
        end
        if (rf_write_enable && (rf_write_address == rs1)) rs1_busy = 1'b1;
        if (rf_write_enable && (rf_write_address == rs2)) rs2_busy = 1'b1;
        if (mem_valid && (mem_addr == rs1)) rs1_busy = 1'b1;
        if (mem_valid && (mem_addr == rs2)) rs2_busy = 1'b1;
        if (rs1 == '0) rs1_busy = 1'b0;
        if (rs2 == '0) rs2_busy = 1'b0;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              reset;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_address;
    logic [DATA_W-1:0] rf_write_value;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              rs1_busy;
    logic              rs2_busy;
    logic [CNT_W-1:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
        .rf_write_value(rf_write_value),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of pending results plus the write port.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              mq[$];
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_val;

    task automatic model_reset();
        mq.delete();
        m_we   = 1'b0;
        m_addr = '0;
        m_val  = '0;
    endtask

    function automatic logic model_busy(input logic [ADDR_W-1:0] r);
        if (r == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].a == r) return 1'b1;
        if (m_we && m_addr == r) return 1'b1;
        if (mem_valid && mem_addr == r) return 1'b1;
        return 1'b0;
    endfunction

    // Advance model and DUT through one rising edge; returns #1 after the edge.
    task automatic tick();
        logic accepted;
        ent_t e;
        accepted = alu_valid && (mq.size() < DEPTH) && (alu_addr != '0);
        if (mem_valid && mem_addr != '0) begin
            m_we = 1'b1; m_addr = mem_addr; m_val = mem_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_addr = e.a; m_val = e.d;
        end else if (accepted) begin
            m_we = 1'b1; m_addr = alu_addr; m_val = alu_data;
            accepted = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        e.a = alu_addr;
        e.d = alu_data;
        if (accepted) mq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        rs1 = '0; rs2 = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #12;
        checks++;
        if (rf_write_enable !== 1'b0 || rf_write_address !== '0 || rf_write_value !== '0) begin
            errors++;
            $display("FAIL reset_outputs got we=%0b addr=%0d val=%h want 0/0/0",
                     rf_write_enable, rf_write_address, rf_write_value);
        end
        checks++;
        if (fifo_count !== '0 || alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_count got count=%0d ready=%0b want 0/1", fifo_count, alu_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_bypass();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        checks++;
        if (rf_write_enable !== 1'b1 || rf_write_address !== 5'd5 || rf_write_value !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_write got we=%0b addr=%0d val=%h want 1/5/deadbeef",
                     rf_write_enable, rf_write_address, rf_write_value);
        end
        checks++;
        if (fifo_count !== '0) begin
            errors++;
            $display("FAIL bypass_count got %0d want 0", fifo_count);
        end
        tick();
        checks++;
        if (rf_write_enable !== 1'b0 || rf_write_address !== 5'd5) begin
            errors++;
            $display("FAIL bypass_idle got we=%0b addr=%0d want 0/5", rf_write_enable, rf_write_address);
        end
    endtask

    task automatic test_mem_priority();
        logic [ADDR_W-1:0] alu_a [3];
        logic [DATA_W-1:0] alu_d [3];
        logic [ADDR_W-1:0] exp_a [6];
        logic [DATA_W-1:0] exp_d [6];
        int unsigned       exp_c [6];
        int k;
        alu_a[0] = 5'd7; alu_a[1] = 5'd8; alu_a[2] = 5'd9;
        alu_d[0] = 32'h22; alu_d[1] = 32'h33; alu_d[2] = 32'h44;
        exp_a[0] = 5'd3; exp_a[1] = 5'd3; exp_a[2] = 5'd3;
        exp_a[3] = 5'd7; exp_a[4] = 5'd8; exp_a[5] = 5'd9;
        exp_d[0] = 32'h11; exp_d[1] = 32'h11; exp_d[2] = 32'h11;
        exp_d[3] = 32'h22; exp_d[4] = 32'h33; exp_d[5] = 32'h44;
        exp_c[0] = 1; exp_c[1] = 2; exp_c[2] = 2; exp_c[3] = 1; exp_c[4] = 1; exp_c[5] = 0;
        k = 0;
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h11;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) mem_valid = 1'b0;
            if (k < 3) begin
                alu_valid = 1'b1; alu_addr = alu_a[k]; alu_data = alu_d[k];
            end else begin
                alu_valid = 1'b0;
            end
            #1;
            if (i == 2 || i == 3) begin
                checks++;
                if (alu_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL prio_ready_full cycle %0d got %0b want 0", i, alu_ready);
                end
            end
            if (alu_valid && alu_ready) k++;
            tick();
            checks++;
            if (rf_write_enable !== 1'b1 || rf_write_address !== exp_a[i] || rf_write_value !== exp_d[i]) begin
                errors++;
                $display("FAIL prio_write cycle %0d got we=%0b addr=%0d val=%h want 1/%0d/%h",
                         i, rf_write_enable, rf_write_address, rf_write_value, exp_a[i], exp_d[i]);
            end
            checks++;
            if (fifo_count !== CNT_W'(exp_c[i])) begin
                errors++;
                $display("FAIL prio_count cycle %0d got %0d want %0d", i, fifo_count, exp_c[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_zero_filter();
        alu_valid = 1'b1; alu_addr = '0; alu_data = 32'hFFFFFFFF;
        mem_valid = 1'b1; mem_addr = '0; mem_data = 32'h12345678;
        rs1 = '0;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_hs got ready=%0b rs1_busy=%0b want 1/0", alu_ready, rs1_busy);
        end
        tick();
        checks++;
        if (rf_write_enable !== 1'b0 || fifo_count !== '0) begin
            errors++;
            $display("FAIL zero_drop got we=%0b count=%0d want 0/0", rf_write_enable, fifo_count);
        end
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h66;
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h44;
        tick();
        alu_valid = 1'b0;
        rs1 = 5'd4; rs2 = 5'd6;
        #1;
        checks++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
            errors++;
            $display("FAIL sb_both got rs1=%0b rs2=%0b want 1/1", rs1_busy, rs2_busy);
        end
        tick();
        mem_valid = 1'b0;
        #1;
        checks++;
        if (rs1_busy !== 1'b1 || fifo_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL sb_queued got rs1=%0b count=%0d want 1/1", rs1_busy, fifo_count);
        end
        tick();
        checks++;
        if (rs1_busy !== 1'b1 || rf_write_enable !== 1'b1 || rf_write_address !== 5'd4) begin
            errors++;
            $display("FAIL sb_outstage got rs1=%0b we=%0b addr=%0d want 1/1/4",
                     rs1_busy, rf_write_enable, rf_write_address);
        end
        tick();
        checks++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear got rs1=%0b rs2=%0b want 0/0", rs1_busy, rs2_busy);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h1;
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hA;
        tick();
        alu_addr = 5'd11; alu_data = 32'hB;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        rs1 = 5'd10; rs2 = 5'd11;
        #1;
        checks++;
        if (fifo_count !== CNT_W'(2) || rf_write_enable !== 1'b1 || rs1_busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got count=%0d we=%0b rs1=%0b want 2/1/1",
                     fifo_count, rf_write_enable, rs1_busy);
        end
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (rf_write_enable !== 1'b0 || rf_write_address !== '0 || rf_write_value !== '0 ||
            fifo_count !== '0) begin
            errors++;
            $display("FAIL rstmid_clear got we=%0b addr=%0d val=%h count=%0d want 0/0/0/0",
                     rf_write_enable, rf_write_address, rf_write_value, fifo_count);
        end
        checks++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy got rs1=%0b rs2=%0b ready=%0b want 0/0/1",
                     rs1_busy, rs2_busy, alu_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'hC0FFEE;
        tick();
        alu_valid = 1'b0;
        checks++;
        if (rf_write_enable !== 1'b1 || rf_write_address !== 5'd12 || rf_write_value !== 32'hC0FFEE) begin
            errors++;
            $display("FAIL rstmid_after got we=%0b addr=%0d val=%h want 1/12/c0ffee",
                     rf_write_enable, rf_write_address, rf_write_value);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_addr  = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
            alu_data  = $urandom;
            mem_valid = ($urandom_range(0, 2) == 0);
            mem_addr  = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
            mem_data  = $urandom;
            rs1       = ADDR_W'($urandom);
            rs2       = (n % 2 == 0) ? m_addr : ADDR_W'($urandom);
            #1;
            checks++;
            if (alu_ready !== (mq.size() < DEPTH) || rs1_busy !== model_busy(rs1) ||
                rs2_busy !== model_busy(rs2)) begin
                errors++;
                $display("FAIL rand_comb n=%0d got ready=%0b b1=%0b b2=%0b want %0b/%0b/%0b",
                         n, alu_ready, rs1_busy, rs2_busy,
                         (mq.size() < DEPTH), model_busy(rs1), model_busy(rs2));
            end
            tick();
            checks++;
            if (rf_write_enable !== m_we || rf_write_address !== m_addr ||
                rf_write_value !== m_val || fifo_count !== CNT_W'(mq.size())) begin
                errors++;
                $display("FAIL rand_write n=%0d got we=%0b addr=%0d val=%h cnt=%0d want %0b/%0d/%h/%0d",
                         n, rf_write_enable, rf_write_address, rf_write_value, fifo_count,
                         m_we, m_addr, m_val, mq.size());
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        model_reset();
        test_bypass();
        test_mem_priority();
        test_zero_filter();
        test_scoreboard();
        test_reset_mid();
        model_reset();
        m_we = rf_write_enable; m_addr = rf_write_address; m_val = rf_write_value;
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
